// File: rtl/seq_det_pkg.sv
// seq_det shared types: state encoding, symbol geometry and default pattern.
// next_len() computes the overlap fallback for any PATTERN value.
package seq_det_pkg;

  localparam int SYM_W   = 2;
  localparam int PAT_LEN = 4;
  localparam int PAT_W   = SYM_W * PAT_LEN;

  localparam logic [PAT_W-1:0] DEF_PATTERN = 8'h6D;

  typedef enum logic [2:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3
  } state_e;

  function automatic logic [SYM_W-1:0] pat_sym(
    input logic [PAT_W-1:0] pat,
    input int               i
  );
    return pat[PAT_W-1-SYM_W*i -: SYM_W];
  endfunction

  // History is the first k pattern symbols followed by s; return the
  // longest suffix (at most PAT_LEN-1 long) that is also a pattern prefix.
  function automatic logic [2:0] next_len(
    input logic [PAT_W-1:0] pat,
    input logic [2:0]       k,
    input logic [SYM_W-1:0] s
  );
    logic [SYM_W-1:0] h [PAT_LEN];
    logic [2:0]       best;
    logic             ok;
    int               idx;
    best = '0;
    for (int j = 0; j < PAT_LEN; j++) begin
      h[j] = (j < int'(k)) ? pat_sym(pat, j) : s;
    end
    for (int l = 1; l < PAT_LEN; l++) begin
      if (l <= int'(k) + 1) begin
        ok = 1'b1;
        for (int i = 0; i < PAT_LEN - 1; i++) begin
          if (i < l) begin
            idx = int'(k) + 1 - l + i;
            if (h[idx] != pat_sym(pat, i)) ok = 1'b0;
          end
        end
        if (ok) best = 3'(l);
      end
    end
    return best;
  endfunction

  function automatic state_e len_state(input logic [2:0] l);
    state_e st;
    st = M0;
    unique case (1'b1)
      (l == 3'd1): st = M1;
      (l == 3'd2): st = M2;
      (l == 3'd3): st = M3;
      default:     st = M0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/seq_det_led_stretch.sv
// Retriggerable LED on-time stretcher with active-low output.
// Each trigger reloads the full LEN-clock on-time; clr forces it off.
module led_stretch
  import seq_det_pkg::*;
#(
  parameter int unsigned LEN = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  input  logic clr,
  output logic led_n
);

  localparam int W = $clog2(LEN + 1);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (trig) begin
      cnt_nxt = W'(LEN);
    end else if (cnt != '0) begin
      cnt_nxt = cnt - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      led_n <= 1'b1;
    end else begin
      cnt   <= cnt_nxt;
      led_n <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/seq_det.sv
// Four-symbol overlapping sequence detector with hit counter and LED.
// Define SEQ_DET_HOLD_EN to latch the LED for the session instead of stretching.
module seq_det
  import seq_det_pkg::*;
#(
  parameter logic [PAT_W-1:0] PATTERN     = DEF_PATTERN,
  parameter int               CNT_W       = 8,
  parameter int unsigned      LED_STRETCH = 24'd2_700_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det_en,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  output logic             det_pulse,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [2:0]       match_len,
  output logic             det_led_n
);

  state_e     state;
  logic [2:0] nxt_len;
  logic       hit;

  assign nxt_len = next_len(PATTERN, match_len, sym_data);

  // Disable has priority, so a symbol arriving with det_en low never hits.
  assign hit = det_en && sym_valid && (state == M3) &&
               (sym_data == pat_sym(PATTERN, PAT_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      match_len <= '0;
      hit_cnt   <= '0;
      det_pulse <= 1'b0;
    end else begin
      det_pulse <= hit;
      if (!det_en) begin
        state     <= IDLE;
        match_len <= '0;
      end else if (state == IDLE) begin
        state     <= M0;
        match_len <= '0;
        hit_cnt   <= '0;
      end else if (sym_valid) begin
        state     <= len_state(nxt_len);
        match_len <= nxt_len;
        if (hit && (hit_cnt != '1)) begin
          hit_cnt <= hit_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef SEQ_DET_HOLD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_led_n <= 1'b1;
    end else if (!det_en) begin
      det_led_n <= 1'b1;
    end else if (hit) begin
      det_led_n <= 1'b0;
    end
  end
`else
  led_stretch #(
    .LEN (LED_STRETCH)
  ) u_led (
    .clk   (clk),
    .rst_n (rst_n),
    .trig  (hit),
    .clr   (!det_en),
    .led_n (det_led_n)
  );
`endif

endmodule

// File: tb/tb_seq_det.sv
// Directed bench for seq_det (CNT_W=2, LED_STRETCH=10).
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_seq_det;

  logic       clk;
  logic       rst_n;
  logic       det_en;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       det_pulse;
  logic [1:0] hit_cnt;
  logic [2:0] match_len;
  logic       det_led_n;

  int errors = 0;
  int checks = 0;

  seq_det #(
    .PATTERN     (8'h6D),
    .CNT_W       (2),
    .LED_STRETCH (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .det_en    (det_en),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .det_pulse (det_pulse),
    .hit_cnt   (hit_cnt),
    .match_len (match_len),
    .det_led_n (det_led_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [1:0] s);
    sym_valid = 1'b1;
    sym_data  = s;
    @(negedge clk);
  endtask

  task automatic idle();
    sym_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic enable();
    sym_valid = 1'b0;
    det_en    = 1'b0;
    @(negedge clk);
    det_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic disable_det();
    sym_valid = 1'b0;
    det_en    = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    det_en    = 1'b0;
    sym_valid = 1'b0;
    sym_data  = 2'b00;
    repeat (2) @(negedge clk);
    checks++;
    if ({det_pulse, hit_cnt, match_len, det_led_n} !== 7'b0_00_000_1) begin
      errors++;
      $display("FAIL reset: got p=%b c=%0d m=%0d led=%b want 0 0 0 1",
               det_pulse, hit_cnt, match_len, det_led_n);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [1:0] syms [4] = '{2'b01, 2'b10, 2'b11, 2'b01};
    logic [2:0] exp_m [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
    enable();
    for (int i = 0; i < 4; i++) begin
      send(syms[i]);
      checks++;
      if (det_pulse !== (i == 3) || match_len !== exp_m[i]) begin
        errors++;
        $display("FAIL basic[%0d]: pulse=%b len=%0d want %b %0d",
                 i, det_pulse, match_len, (i == 3), exp_m[i]);
      end
    end
    checks++;
    if (hit_cnt !== 2'd1 || det_led_n !== 1'b0) begin
      errors++;
      $display("FAIL basic_hit: cnt=%0d led=%b want 1 0", hit_cnt, det_led_n);
    end
    idle();
    checks++;
    if (det_pulse !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse_width: pulse=%b want 0", det_pulse);
    end
    disable_det();
    checks++;
    if (hit_cnt !== 2'd1 || match_len !== 3'd0 || det_led_n !== 1'b1) begin
      errors++;
      $display("FAIL basic_disable: cnt=%0d len=%0d led=%b want 1 0 1",
               hit_cnt, match_len, det_led_n);
    end
  endtask

  task automatic test_overlap();
    logic [1:0] syms [7] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [2:0] exp_m [7] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1};
    logic       exp_p [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    enable();
    checks++;
    if (hit_cnt !== 2'd0) begin
      errors++;
      $display("FAIL overlap_clear: cnt=%0d want 0", hit_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      send(syms[i]);
      checks++;
      if (det_pulse !== exp_p[i] || match_len !== exp_m[i]) begin
        errors++;
        $display("FAIL overlap[%0d]: pulse=%b len=%0d want %b %0d",
                 i, det_pulse, match_len, exp_p[i], exp_m[i]);
      end
    end
    checks++;
    if (hit_cnt !== 2'd2) begin
      errors++;
      $display("FAIL overlap_cnt: cnt=%0d want 2", hit_cnt);
    end
    disable_det();
  endtask

  task automatic test_fallback();
    logic [1:0] syms [5] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b01};
    logic [2:0] exp_m [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd1};
    enable();
    for (int i = 0; i < 5; i++) begin
      send(syms[i]);
      checks++;
      if (det_pulse !== (i == 4) || match_len !== exp_m[i]) begin
        errors++;
        $display("FAIL fallback[%0d]: pulse=%b len=%0d want %b %0d",
                 i, det_pulse, match_len, (i == 4), exp_m[i]);
      end
    end
    checks++;
    if (hit_cnt !== 2'd1) begin
      errors++;
      $display("FAIL fallback_cnt: cnt=%0d want 1", hit_cnt);
    end
    disable_det();
  endtask

  task automatic test_disable_drop();
    logic [1:0] syms [6] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
    enable();
    for (int i = 0; i < 6; i++) send(syms[i]);
    checks++;
    if (match_len !== 3'd3 || hit_cnt !== 2'd1) begin
      errors++;
      $display("FAIL drop_setup: len=%0d cnt=%0d want 3 1", match_len, hit_cnt);
    end
    det_en = 1'b0;
    send(2'b01);
    checks++;
    if (det_pulse !== 1'b0 || match_len !== 3'd0 || det_led_n !== 1'b1 ||
        hit_cnt !== 2'd1) begin
      errors++;
      $display("FAIL drop: pulse=%b len=%0d led=%b cnt=%0d want 0 0 1 1",
               det_pulse, match_len, det_led_n, hit_cnt);
    end
    idle();
    checks++;
    if (det_pulse !== 1'b0) begin
      errors++;
      $display("FAIL drop_late_pulse: pulse=%b want 0", det_pulse);
    end
    enable();
    checks++;
    if (hit_cnt !== 2'd0 || match_len !== 3'd0) begin
      errors++;
      $display("FAIL reenable: cnt=%0d len=%0d want 0 0", hit_cnt, match_len);
    end
    disable_det();
  endtask

  task automatic test_saturate();
    logic [1:0] tail [3] = '{2'b10, 2'b11, 2'b01};
    logic [1:0] exp_c;
    enable();
    send(2'b01);
    for (int h = 1; h <= 6; h++) begin
      for (int j = 0; j < 3; j++) send(tail[j]);
      exp_c = (h >= 3) ? 2'd3 : 2'(h);
      checks++;
      if (det_pulse !== 1'b1 || hit_cnt !== exp_c) begin
        errors++;
        $display("FAIL saturate[%0d]: pulse=%b cnt=%0d want 1 %0d",
                 h, det_pulse, hit_cnt, exp_c);
      end
    end
    disable_det();
  endtask

  task automatic test_led();
    logic exp_led;
    logic [1:0] pre [3] = '{2'b01, 2'b10, 2'b11};
    enable();
    for (int i = 0; i < 3; i++) send(pre[i]);
    send(2'b01);
    for (int c = 1; c <= 11; c++) begin
`ifdef SEQ_DET_HOLD_EN
      exp_led = 1'b0;
`else
      exp_led = (c > 10);
`endif
      checks++;
      if (det_led_n !== exp_led) begin
        errors++;
        $display("FAIL led_single[c%0d]: led=%b want %b", c, det_led_n, exp_led);
      end
      if (c < 11) idle();
    end
    disable_det();
    enable();
    for (int i = 0; i < 3; i++) send(pre[i]);
    send(2'b01);
    for (int c = 1; c <= 15; c++) begin
`ifdef SEQ_DET_HOLD_EN
      exp_led = 1'b0;
`else
      exp_led = (c >= 15);
`endif
      checks++;
      if (det_led_n !== exp_led) begin
        errors++;
        $display("FAIL led_retrig[c%0d]: led=%b want %b", c, det_led_n, exp_led);
      end
      unique case (c)
        2:       send(2'b10);
        3:       send(2'b11);
        4:       send(2'b01);
        default: idle();
      endcase
    end
    disable_det();
    checks++;
    if (det_led_n !== 1'b1) begin
      errors++;
      $display("FAIL led_off: led=%b want 1", det_led_n);
    end
  endtask

  task automatic test_reset_mid();
    enable();
    send(2'b01);
    send(2'b10);
    rst_n = 1'b0;
    #1;
    checks++;
    if (match_len !== 3'd0 || hit_cnt !== 2'd0 || det_led_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: len=%0d cnt=%0d led=%b want 0 0 1",
               match_len, hit_cnt, det_led_n);
    end
    sym_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_fallback();
    test_disable_drop();
    test_saturate();
    test_led();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
